// File: rtl/fifo_read_packer_if.sv
`default_nettype none
// ============================================================================
// fifo_read_packer_if
// FIFO read port plus packed-beat valid/ready stream for fifo_read_packer.
// Revision: 1.0
// ============================================================================
interface fifo_read_packer_if #(
  parameter int BITS  = 32,
  parameter int RATIO = 4
);
  localparam int CW = $clog2(RATIO + 1);

  logic                  p_read_en;
  logic [BITS-1:0]       p_read_data;
  logic                  p_read_empty;
  logic                  p_out_valid;
  logic                  p_out_ready;
  logic [BITS*RATIO-1:0] p_out_data;
  logic [CW-1:0]         p_out_words;

  modport master (
    output p_read_en,
    input  p_read_data,
    input  p_read_empty,
    output p_out_valid,
    input  p_out_ready,
    output p_out_data,
    output p_out_words
  );

  modport slave (
    input  p_read_en,
    output p_read_data,
    output p_read_empty,
    input  p_out_valid,
    output p_out_ready,
    input  p_out_data,
    input  p_out_words
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_packer.sv
`default_nettype none
// ============================================================================
// fifo_read_packer
// Pops RATIO words from async_fifo (read_clk domain) and presents them as one
// packed valid/ready beat. Optional partial-beat flush: FIFO_READ_PACKER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module fifo_read_packer #(
  parameter int BITS           = 32,
  parameter int RATIO          = 4,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               read_clk,
  input  logic               read_rst,
  fifo_read_packer_if.master bus
);
  localparam int CW = $clog2(RATIO + 1);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         captured, captured_n;
  logic                  in_flight, in_flight_n;
  logic [BITS*RATIO-1:0] beat, beat_n;
  logic [CW-1:0]         words, words_n;
  logic [CW:0]           occupancy;
  logic                  read_en;
  logic                  cap;
  logic                  flush;

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $fatal(1, "fifo_read_packer: READ_LATENCY must be 0 or 1");
  end
  if (RATIO < 2) begin : g_bad_ratio
    $fatal(1, "fifo_read_packer: RATIO must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $fatal(1, "fifo_read_packer: TIMEOUT_CYCLES must be at least 1");
  end

  // Words already captured plus the one still in flight must not exceed a beat.
  assign occupancy = {1'b0, captured} + {{CW{1'b0}}, in_flight};
  assign read_en   = !read_rst && (state == FILL) && !bus.p_read_empty &&
                     (occupancy < (CW+1)'(RATIO));
  assign cap       = (READ_LATENCY == 0) ? read_en : in_flight;

`ifdef FIFO_READ_PACKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle, idle_n;
  logic          idle_cond;

  assign idle_cond = (state == FILL) && (captured != '0) && (captured < CW'(RATIO)) &&
                     !in_flight && bus.p_read_empty;
  assign flush     = idle_cond && (idle == TW'(TIMEOUT_CYCLES));

  always_comb begin
    idle_n = idle;
    if (cap || flush) begin
      idle_n = '0;
    end else if (idle_cond) begin
      idle_n = idle + 1'b1;
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      idle <= '0;
    end else begin
      idle <= idle_n;
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    captured_n  = captured;
    in_flight_n = 1'b0;
    beat_n      = beat;
    words_n     = words;
    case (state)
      FILL: begin
        in_flight_n = (READ_LATENCY != 0) && read_en;
        if (cap) begin
          for (int k = 0; k < RATIO; k++) begin
            if (captured == CW'(k)) begin
              beat_n[k*BITS +: BITS] = bus.p_read_data;
            end
          end
          captured_n = captured + 1'b1;
        end
        if ((captured_n == CW'(RATIO)) || flush) begin
          state_n = HOLD;
          words_n = captured_n;
        end
      end
      HOLD: begin
        // Clearing the beat here keeps unfilled upper words zero on a flushed beat.
        if (bus.p_out_ready) begin
          state_n    = FILL;
          captured_n = '0;
          beat_n     = '0;
          words_n    = '0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      state     <= FILL;
      captured  <= '0;
      in_flight <= 1'b0;
      beat      <= '0;
      words     <= '0;
    end else begin
      state     <= state_n;
      captured  <= captured_n;
      in_flight <= in_flight_n;
      beat      <= beat_n;
      words     <= words_n;
    end
  end

  assign bus.p_read_en   = read_en;
  assign bus.p_out_valid = (state == HOLD);
  assign bus.p_out_data  = beat;
  assign bus.p_out_words = words;
endmodule
`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
`default_nettype none
// Two packers (READ_LATENCY 0 and 1) run in lockstep, each fed by its own FIFO
// model; accepted beats are compared with the pushed word stream chunked by RATIO.
module tb_fifo_read_packer;
  localparam int BITS  = 32;
  localparam int RATIO = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_packer_if #(.BITS(BITS), .RATIO(RATIO)) if0 ();
  fifo_read_packer_if #(.BITS(BITS), .RATIO(RATIO)) if1 ();

  fifo_read_packer #(.BITS(BITS), .RATIO(RATIO), .READ_LATENCY(0), .TIMEOUT_CYCLES(TMO))
    dut0 (.read_clk(clk), .read_rst(rst), .bus(if0.master));
  fifo_read_packer #(.BITS(BITS), .RATIO(RATIO), .READ_LATENCY(1), .TIMEOUT_CYCLES(TMO))
    dut1 (.read_clk(clk), .read_rst(rst), .bus(if1.master));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rdy;
  logic [31:0] pend1;

  logic [31:0]  mem [2][0:255];
  int           wp [2];
  int           rp [2];
  logic [31:0]  ex [2][0:255];
  int           ne [2];
  logic [127:0] bdata [2][0:31];
  logic [2:0]   bwords [2][0:31];
  int           nb [2];
  int           pops [2];
  int           bad_empty [2];
  int           bad_rst [2];
  int           unstable [2];
  logic         held [2];
  logic [127:0] hdata [2];
  logic [2:0]   hwords [2];
  logic         pvalid [2];
  int           last_pop [2];
  int           rise [2];

  function automatic logic en_of(int d);
    return (d == 0) ? if0.p_read_en : if1.p_read_en;
  endfunction
  function automatic logic valid_of(int d);
    return (d == 0) ? if0.p_out_valid : if1.p_out_valid;
  endfunction
  function automatic logic [127:0] data_of(int d);
    return (d == 0) ? if0.p_out_data : if1.p_out_data;
  endfunction
  function automatic logic [2:0] words_of(int d);
    return (d == 0) ? if0.p_out_words : if1.p_out_words;
  endfunction

  function automatic logic [127:0] model_beat(int d, int j, int n);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < n; k++) b[k*32 +: 32] = ex[d][j*RATIO + k];
    return b;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      wp[d] = 0; rp[d] = 0; ne[d] = 0; nb[d] = 0; pops[d] = 0;
      bad_empty[d] = 0; bad_rst[d] = 0; unstable[d] = 0;
      held[d] = 1'b0; pvalid[d] = 1'b0; last_pop[d] = 0; rise[d] = 0;
    end
  endtask

  task automatic push(logic [31:0] w);
    for (int d = 0; d < 2; d++) begin
      mem[d][wp[d]] = w; wp[d]++;
      ex[d][ne[d]] = w;  ne[d]++;
    end
  endtask

  // One read_clk cycle: drive FIFO/ready inputs at negedge, observe, then advance.
  task automatic step();
    logic en, v, emp;
    logic [127:0] dat;
    logic [2:0] wd;
    if0.p_out_ready  = rdy;
    if1.p_out_ready  = rdy;
    if0.p_read_empty = (wp[0] == rp[0]);
    if0.p_read_data  = (wp[0] != rp[0]) ? mem[0][rp[0]] : 32'h0;
    if1.p_read_empty = (wp[1] == rp[1]);
    if1.p_read_data  = pend1;
    #1;
    for (int d = 0; d < 2; d++) begin
      en  = en_of(d);
      v   = valid_of(d);
      dat = data_of(d);
      wd  = words_of(d);
      emp = (wp[d] == rp[d]);
      if (en === 1'b1) begin
        pops[d]++;
        last_pop[d] = cyc;
        if (emp) bad_empty[d]++;
        if (rst) bad_rst[d]++;
        if (!emp) begin
          if (d == 1) pend1 = mem[d][rp[d]];
          rp[d]++;
        end
      end
      if (held[d] && (v !== 1'b1 || dat !== hdata[d] || wd !== hwords[d])) unstable[d]++;
      if (v === 1'b1 && !pvalid[d]) rise[d] = cyc;
      if (v === 1'b1 && rdy && nb[d] < 32) begin
        bdata[d][nb[d]]  = dat;
        bwords[d][nb[d]] = wd;
        nb[d]++;
      end
      held[d]   = (v === 1'b1) && !rdy;
      hdata[d]  = dat;
      hwords[d] = wd;
      pvalid[d] = (v === 1'b1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic run_beats(int n, int budget);
    int k;
    k = 0;
    while ((nb[0] < n || nb[1] < n) && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic check_beats(string tag, int nexp);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_nbeats_lat%0d", tag, d), nb[d], nexp);
      for (int j = 0; j < nexp && j < nb[d]; j++) begin
        chk($sformatf("%s_data%0d_lat%0d", tag, j, d), bdata[d][j], model_beat(d, j, RATIO));
        chk($sformatf("%s_words%0d_lat%0d", tag, j, d), bwords[d][j], RATIO);
      end
    end
  endtask

  task automatic health(string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_pop_when_empty_lat%0d", tag, d), bad_empty[d], 0);
      chk($sformatf("%s_unstable_hold_lat%0d", tag, d), unstable[d], 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b0;
    pend1 = 32'h0;
    if0.p_out_ready = 1'b0;  if1.p_out_ready = 1'b0;
    if0.p_read_empty = 1'b1; if1.p_read_empty = 1'b1;
    if0.p_read_data = 32'h0; if1.p_read_data = 32'h0;
    clear_model();
    @(negedge clk);
    run(2);

    // Reset held with a non-empty FIFO, then the first beat.
    clear_model();
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    rdy = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_en%0d_lat%0d", i, d), en_of(d), 1'b0);
        chk($sformatf("rst_valid%0d_lat%0d", i, d), valid_of(d), 1'b0);
        chk($sformatf("rst_words%0d_lat%0d", i, d), words_of(d), 3'd0);
      end
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post_rst_valid_lat%0d", d), valid_of(d), 1'b0);
      chk($sformatf("rst_pops_lat%0d", d), bad_rst[d], 0);
    end
    run_beats(1, 40);
    run(3);
    check_beats("basic", 1);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("basic_literal_lat%0d", d), bdata[d][0],
          128'h00000044_00000033_00000022_00000011);
      chk($sformatf("basic_pops_lat%0d", d), pops[d], 4);
    end
    health("basic");

    // Backpressure: 8 words, ready low for 20 cycles.
    clear_model();
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) push($urandom);
    run(20);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_pops_lat%0d", d), pops[d], 4);
      chk($sformatf("bp_valid_lat%0d", d), valid_of(d), 1'b1);
      chk($sformatf("bp_hold_data_lat%0d", d), data_of(d), model_beat(d, 0, RATIO));
    end
    rdy = 1'b1;
    run_beats(2, 60);
    run(3);
    check_beats("bp", 2);
    for (int d = 0; d < 2; d++) chk($sformatf("bp_pops_total_lat%0d", d), pops[d], 8);
    health("bp");

    // Empty gap mid-fill.
    clear_model();
    rdy = 1'b1;
    push($urandom); push($urandom);
    run(12);
    for (int d = 0; d < 2; d++) chk($sformatf("gap_no_beat_lat%0d", d), nb[d], 0);
    push($urandom); push($urandom);
    run_beats(1, 40);
    run(2);
    check_beats("gap", 1);
    health("gap");

    // Reset after two captured words: they must be discarded.
    clear_model();
    push($urandom); push($urandom);
    run(6);
    for (int d = 0; d < 2; d++) chk($sformatf("midrst_pops_lat%0d", d), pops[d], 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) push($urandom);
    run_beats(1, 40);
    run(2);
    check_beats("midrst", 1);
    health("midrst");

    // Partial beat: three words, then the FIFO stays empty.
    clear_model();
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) push($urandom);
`ifdef FIFO_READ_PACKER_TIMEOUT_EN
    run_beats(1, 120);
    run(2);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("tmo_nbeats_lat%0d", d), nb[d], 1);
      chk($sformatf("tmo_words_lat%0d", d), bwords[d][0], 3'd3);
      chk($sformatf("tmo_data_lat%0d", d), bdata[d][0], model_beat(d, 0, 3));
      // Capture cycle is the pop cycle plus the read latency (d); valid follows
      // TIMEOUT_CYCLES+1 edges after the capturing edge.
      chk($sformatf("tmo_delay_lat%0d", d), rise[d] - (last_pop[d] + d), TMO + 2);
    end
`else
    run(100);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("partial_no_beat_lat%0d", d), nb[d], 0);
      chk($sformatf("partial_valid_lat%0d", d), valid_of(d), 1'b0);
    end
    push($urandom);
    run_beats(1, 40);
    run(2);
    check_beats("partial", 1);
`endif
    health("partial");

    // Randomized stream with random gaps and random backpressure.
    clear_model();
    for (int i = 0; i < 48; i++) begin
      push($urandom);
      if ($urandom_range(0, 1) == 1) rdy = ($urandom_range(0, 3) != 0);
      run($urandom_range(0, 3));
    end
    rdy = 1'b1;
    run_beats(12, 400);
    run(3);
    check_beats("rand", 12);
    for (int d = 0; d < 2; d++) chk($sformatf("rand_pops_lat%0d", d), pops[d], 48);
    health("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
